// File: rtl/board_pixel_gen.sv
// board_pixel_gen: pixel source for the VGA controller. It draws a 15x15
// Gomoku board with a wood background, grid lines, black and white stones
// and a red frame around the cursor cell.
//
// There are three pipeline stages:
//   S1 registers the scan position and issues the board RAM address.
//   S2 captures the RAM data (1-cycle latency) and the stone-hit test.
//   S3 registers the final colour.
//
// Optional macro CURSOR_BLINK_EN: when defined, the cursor frame blinks every
// BLINK_FRAMES frames. When undefined, the frame is drawn on every frame.
module board_pixel_gen #(
    parameter int X0           = 80,
    parameter int Y0           = 0,
    parameter int STONE_R      = 13,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic [3:0]  cur_x,
    input  logic [3:0]  cur_y,
    output logic [7:0]  brd_addr,
    input  logic [1:0]  brd_data,
    output logic [11:0] d_out
);

    localparam logic [10:0] BOARD_PX = 11'd480;
    localparam logic [10:0] STONE_R2 = 11'(STONE_R * STONE_R);

    // Positions left of or above the board wrap to large values, so a single
    // unsigned compare per axis gives the in-board test.
    logic [10:0] col_rel;
    logic [10:0] row_rel;
    logic        in_board;
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic [7:0]  cell_addr;
    logic        cur_ok;
    logic        cur_hit;

    assign col_rel  = {1'b0, col_addr} - 11'(X0);
    assign row_rel  = {2'b00, row_addr} - 11'(Y0);
    assign in_board = (col_rel < BOARD_PX) && (row_rel < BOARD_PX);
    assign cx       = col_rel[9:5];
    assign cy       = row_rel[9:5];

    // cy*15 + cx written as (cy<<4) - cy + cx. Inside the board cy <= 14,
    // so the top bit of cy is not needed for the shifted term.
    assign cell_addr = {cy[3:0], 4'b0000} - {3'b000, cy} + {3'b000, cx};

    assign cur_ok  = (cur_x <= 4'd14) && (cur_y <= 4'd14);
    assign cur_hit = in_board && cur_ok &&
                     (cx == {1'b0, cur_x}) && (cy == {1'b0, cur_y});

    logic       s1_valid;
    logic       s1_inb;
    logic       s1_cur;
    logic [4:0] s1_ox;
    logic [4:0] s1_oy;

    // S1: latch the scan position and present the board RAM address.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inb   <= 1'b0;
            s1_cur   <= 1'b0;
            s1_ox    <= 5'd0;
            s1_oy    <= 5'd0;
            brd_addr <= 8'd0;
        end else begin
            s1_valid <= ~rdn;
            s1_inb   <= in_board;
            s1_cur   <= cur_hit;
            s1_ox    <= col_rel[4:0];
            s1_oy    <= row_rel[4:0];
            brd_addr <= in_board ? cell_addr : 8'd0;
        end
    end

    // The stone test measures the distance from the cell centre at offset 16.
    logic [4:0]  dx;
    logic [4:0]  dy;
    logic [9:0]  sq_x;
    logic [9:0]  sq_y;
    logic [10:0] dist2;
    logic        stone_hit;
    logic        on_border;
    logic        on_grid;

    assign dx        = s1_ox[4] ? (s1_ox - 5'd16) : (5'd16 - s1_ox);
    assign dy        = s1_oy[4] ? (s1_oy - 5'd16) : (5'd16 - s1_oy);
    assign sq_x      = {5'b00000, dx} * {5'b00000, dx};
    assign sq_y      = {5'b00000, dy} * {5'b00000, dy};
    assign dist2     = {1'b0, sq_x} + {1'b0, sq_y};
    assign stone_hit = dist2 < STONE_R2;
    assign on_border = s1_cur &&
                       ((s1_ox <= 5'd1) || (s1_ox >= 5'd30) ||
                        (s1_oy <= 5'd1) || (s1_oy >= 5'd30));
    assign on_grid   = (s1_ox == 5'd16) || (s1_oy == 5'd16);

    logic       s2_valid;
    logic       s2_inb;
    logic       s2_border;
    logic       s2_hit;
    logic       s2_grid;
    logic [1:0] s2_code;

    // S2: capture the RAM data together with the per-pixel geometry flags.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_inb    <= 1'b0;
            s2_border <= 1'b0;
            s2_hit    <= 1'b0;
            s2_grid   <= 1'b0;
            s2_code   <= 2'b00;
        end else begin
            s2_valid  <= s1_valid;
            s2_inb    <= s1_inb;
            s2_border <= on_border;
            s2_hit    <= stone_hit;
            s2_grid   <= on_grid;
            s2_code   <= brd_data;
        end
    end

    logic show_cursor;

`ifdef CURSOR_BLINK_EN
    logic       frame_tick;
    logic [7:0] blink_cnt;
    logic       blink_on;

    assign frame_tick  = ~rdn && (row_addr == 9'd479) && (col_addr == 10'd639);
    assign show_cursor = blink_on;

    // Count frames and flip the cursor phase every BLINK_FRAMES frames.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            blink_cnt <= 8'd0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt <= 8'd0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end
`else
    assign show_cursor = 1'b1;
`endif

    // S3: pick the colour by priority and register it for the controller.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            d_out <= 12'h000;
        end else if (!s2_valid) begin
            d_out <= 12'h000;
        end else if (!s2_inb) begin
            d_out <= 12'h222;
        end else if (s2_border && show_cursor) begin
            d_out <= 12'h00F;
        end else if (s2_hit && (s2_code == 2'b01)) begin
            d_out <= 12'h000;
        end else if (s2_hit && (s2_code == 2'b10)) begin
            d_out <= 12'hFFF;
        end else if (s2_grid) begin
            d_out <= 12'h000;
        end else begin
            d_out <= 12'h49D;
        end
    end

endmodule
